// File: rtl/mem_access_stage.sv
// Memory stage of the 16-bit pipeline: drives data-memory loads/stores over a req/ack
// handshake, stalls upstream while an access is outstanding, and aborts on timeout.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regWrite,
  input  logic        r0Write,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memSource,
  input  logic [3:0]  RA1,
  input  logic [3:0]  opcode,
  input  logic [15:0] ALUResult,
  input  logic [15:0] DataIn,
  input  logic [15:0] R0D,
  input  logic        fault_clr,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        stall,
  output logic        mem_fault,
  output logic        wb_regWrite,
  output logic        wb_r0Write,
  output logic [3:0]  wb_RA1,
  output logic [3:0]  wb_opcode,
  output logic [15:0] wb_data,
  output logic [15:0] wb_R0D
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        mem_op_s;
  logic        timeout_hit_s;
  logic        req_s, we_s;
  logic [15:0] addr_s, wdata_s;
  logic        fault_set_s, fault_s;
  logic        wb_load_s;
  logic [15:0] wb_data_s;

  assign mem_op_s      = memRead | memWrite;
  assign timeout_hit_s = (cnt_r == CNT_LAST);
  // A timeout set in the same cycle as a clear wins, so the fault is never lost.
  assign fault_s       = fault_set_s ? 1'b1 : (fault_clr ? 1'b0 : mem_fault);

  // Next-state, handshake and stall decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    stall       = 1'b0;
    req_s       = dmem_req;
    we_s        = dmem_we;
    addr_s      = dmem_addr;
    wdata_s     = dmem_wdata;
    fault_set_s = 1'b0;
    wb_load_s   = 1'b0;
    wb_data_s   = ALUResult;
    case (state_r)
      IDLE: begin
        cnt_s = 8'd0;
        if (mem_op_s) begin
          stall   = 1'b1;
          state_s = REQ;
          req_s   = 1'b1;
          we_s    = memWrite;
          addr_s  = ALUResult;
          wdata_s = memSource ? R0D : DataIn;
        end else begin
          wb_load_s = 1'b1;
        end
      end
      REQ: begin
        // Stall drops on the final cycle so upstream advances on the completing edge.
        stall = ~dmem_ack & ~timeout_hit_s;
        if (dmem_ack) begin
          wb_load_s = 1'b1;
          wb_data_s = memWrite ? ALUResult : dmem_rdata;
          req_s     = 1'b0;
          cnt_s     = 8'd0;
          state_s   = IDLE;
        end else if (timeout_hit_s) begin
          req_s       = 1'b0;
          fault_set_s = 1'b1;
          cnt_s       = 8'd0;
          state_s     = IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
        req_s   = 1'b0;
      end
    endcase
  end

  // FSM, cycle counter, memory request and fault registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 16'h0000;
      dmem_wdata <= 16'h0000;
      mem_fault  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      dmem_req   <= req_s;
      dmem_we    <= we_s;
      dmem_addr  <= addr_s;
      dmem_wdata <= wdata_s;
      mem_fault  <= fault_s;
    end
  end

  // MEM/WB register; anything other than a retiring instruction becomes a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_regWrite <= 1'b0;
      wb_r0Write  <= 1'b0;
      wb_RA1      <= 4'h0;
      wb_opcode   <= 4'h0;
      wb_data     <= 16'h0000;
      wb_R0D      <= 16'h0000;
    end else if (wb_load_s) begin
      wb_regWrite <= regWrite;
      wb_r0Write  <= r0Write;
      wb_RA1      <= RA1;
      wb_opcode   <= opcode;
      wb_data     <= wb_data_s;
      wb_R0D      <= R0D;
    end else begin
      wb_regWrite <= 1'b0;
      wb_r0Write  <= 1'b0;
      wb_RA1      <= 4'h0;
      wb_opcode   <= 4'h0;
      wb_data     <= 16'h0000;
      wb_R0D      <= 16'h0000;
    end
  end

endmodule
